// File: rtl/video_pkg.sv
// Shared XVGA geometry, counter widths and the sprite channel record.
// Imported by the sprite engine and its per-channel hit test.
package video_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;
    localparam int COLOR_MAX_W  = 8;

    typedef struct packed {
        logic [HCOUNT_W-1:0]    x;
        logic [VCOUNT_W-1:0]    y;
        logic                   dx_neg;
        logic                   dy_neg;
        logic                   en;
        logic [COLOR_MAX_W-1:0] color;
    } chan_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational containment test of one rectangle against hcount/vcount.
// Edge sums are one bit wider than the coordinates so they never wrap.
module rect_hit
    import video_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64
) (
    input  logic [HCOUNT_W-1:0] x,
    input  logic [VCOUNT_W-1:0] y,
    input  logic                en,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    output logic                hit
);

    localparam logic [HCOUNT_W:0] W_EXT = (HCOUNT_W+1)'(WIDTH);
    localparam logic [VCOUNT_W:0] H_EXT = (VCOUNT_W+1)'(HEIGHT);

    logic [HCOUNT_W:0] w_x_end;
    logic [VCOUNT_W:0] w_y_end;

    assign w_x_end = {1'b0, x} + W_EXT;
    assign w_y_end = {1'b0, y} + H_EXT;

    // Point is inside when it lies in [x, x+WIDTH) and [y, y+HEIGHT)
    assign hit = en
               & (hcount >= x)
               & ({1'b0, hcount} < w_x_end)
               & (vcount >= y)
               & ({1'b0, vcount} < w_y_end);

endmodule

// File: rtl/rect_sprite_engine.sv
// Multi-rectangle bouncing sprite generator for the XVGA pixel path.
// Holds per-channel state, moves once per frame, emits one registered pixel.
module rect_sprite_engine
    import video_pkg::*;
#(
    parameter int NUM_RECTS = 4,
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int COLOR_W   = 3,
    parameter int STEP      = 2,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF
) (
    input  logic                vclock,
    input  logic                reset,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic                frame_tick,
    input  logic                wr_en,
    input  logic [2:0]          wr_idx,
    input  logic [HCOUNT_W-1:0] wr_x,
    input  logic [VCOUNT_W-1:0] wr_y,
    input  logic [COLOR_W-1:0]  wr_color,
    input  logic                wr_dx_neg,
    input  logic                wr_dy_neg,
    input  logic                wr_enable,
    output logic [COLOR_W-1:0]  pixel,
    output logic                hit,
    output logic [2:0]          hit_idx
);

    localparam int XW = HCOUNT_W + 1;
    localparam int YW = VCOUNT_W + 1;

    localparam logic [XW-1:0]       X_STEP = XW'(STEP);
    localparam logic [XW-1:0]       X_SPAN = XW'(STEP + WIDTH);
    localparam logic [XW-1:0]       X_LIM  = XW'(H_ACTIVE);
    localparam logic [HCOUNT_W-1:0] X_MAX  = HCOUNT_W'(H_ACTIVE - WIDTH);
    localparam logic [HCOUNT_W-1:0] X_D    = HCOUNT_W'(STEP);

    localparam logic [YW-1:0]       Y_STEP = YW'(STEP);
    localparam logic [YW-1:0]       Y_SPAN = YW'(STEP + HEIGHT);
    localparam logic [YW-1:0]       Y_LIM  = YW'(V_ACTIVE);
    localparam logic [VCOUNT_W-1:0] Y_MAX  = VCOUNT_W'(V_ACTIVE - HEIGHT);
    localparam logic [VCOUNT_W-1:0] Y_D    = VCOUNT_W'(STEP);

    chan_t r_chan [NUM_RECTS];
    chan_t w_next [NUM_RECTS];

    logic [NUM_RECTS-1:0] w_ch_hit;
    logic                 w_hit;
    logic [2:0]           w_idx;
    logic [COLOR_W-1:0]   w_col;

    logic [COLOR_W-1:0] r_pixel;
    logic               r_hit;
    logic [2:0]         r_hit_idx;

    // Next-frame position and direction of every channel with edge bounce
    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_next[i] = r_chan[i];
            if (r_chan[i].en) begin
                if (!r_chan[i].dx_neg) begin
                    if (({1'b0, r_chan[i].x} + X_SPAN) > X_LIM) begin
                        w_next[i].x      = X_MAX;
                        w_next[i].dx_neg = 1'b1;
                    end else begin
                        w_next[i].x = r_chan[i].x + X_D;
                    end
                end else begin
                    if ({1'b0, r_chan[i].x} < X_STEP) begin
                        w_next[i].x      = '0;
                        w_next[i].dx_neg = 1'b0;
                    end else begin
                        w_next[i].x = r_chan[i].x - X_D;
                    end
                end
                if (!r_chan[i].dy_neg) begin
                    if (({1'b0, r_chan[i].y} + Y_SPAN) > Y_LIM) begin
                        w_next[i].y      = Y_MAX;
                        w_next[i].dy_neg = 1'b1;
                    end else begin
                        w_next[i].y = r_chan[i].y + Y_D;
                    end
                end else begin
                    if ({1'b0, r_chan[i].y} < Y_STEP) begin
                        w_next[i].y      = '0;
                        w_next[i].dy_neg = 1'b0;
                    end else begin
                        w_next[i].y = r_chan[i].y - Y_D;
                    end
                end
            end
        end
    end

    // Channel registers: a config write overrides that channel's frame move
    always_ff @(posedge vclock) begin
        if (reset) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_chan[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (wr_en && (wr_idx == 3'(i))) begin
                    r_chan[i].x      <= wr_x;
                    r_chan[i].y      <= wr_y;
                    r_chan[i].dx_neg <= wr_dx_neg;
                    r_chan[i].dy_neg <= wr_dy_neg;
                    r_chan[i].en     <= wr_enable;
                    r_chan[i].color  <= COLOR_MAX_W'(wr_color);
                end else if (frame_tick) begin
                    r_chan[i] <= w_next[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        rect_hit #(
            .WIDTH  (WIDTH),
            .HEIGHT (HEIGHT)
        ) u_hit (
            .x      (r_chan[g].x),
            .y      (r_chan[g].y),
            .en     (r_chan[g].en),
            .hcount (hcount),
            .vcount (vcount),
            .hit    (w_ch_hit[g])
        );
    end

    // Priority select: scanning downward leaves the lowest covering index
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_col = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (w_ch_hit[i]) begin
                w_hit = 1'b1;
                w_idx = 3'(i);
                w_col = r_chan[i].color[COLOR_W-1:0];
            end
        end
    end

    // One-cycle pixel pipeline register
    always_ff @(posedge vclock) begin
        if (reset) begin
            r_pixel   <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            r_pixel   <= w_col;
            r_hit     <= w_hit;
            r_hit_idx <= w_idx;
        end
    end

    assign pixel   = r_pixel;
    assign hit     = r_hit;
    assign hit_idx = r_hit_idx;

endmodule

// File: tb/tb_rect_sprite_engine.sv
// Directed bench for rect_sprite_engine: hit/priority, bounce, write-vs-tick,
// reset, with positions observed by probing rectangle edges.
module tb_rect_sprite_engine;

    logic        vclock = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        frame_tick;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [10:0] wr_x;
    logic [9:0]  wr_y;
    logic [2:0]  wr_color;
    logic        wr_dx_neg;
    logic        wr_dy_neg;
    logic        wr_enable;
    logic [2:0]  pixel;
    logic        hit;
    logic [2:0]  hit_idx;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 vclock = ~vclock;

    rect_sprite_engine dut (
        .vclock     (vclock),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_color   (wr_color),
        .wr_dx_neg  (wr_dx_neg),
        .wr_dy_neg  (wr_dy_neg),
        .wr_enable  (wr_enable),
        .pixel      (pixel),
        .hit        (hit),
        .hit_idx    (hit_idx)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present a point, then read the registered result one edge later
    task automatic probe(input string tag, input int h, input int v,
                         input logic eh, input logic [2:0] ei,
                         input logic [2:0] ep);
        @(negedge vclock);
        hcount = 11'(h);
        vcount = 10'(v);
        @(negedge vclock);
        check({tag, ".hit"}, 32'(hit), 32'(eh));
        check({tag, ".idx"}, 32'(hit_idx), 32'(ei));
        check({tag, ".pix"}, 32'(pixel), 32'(ep));
    endtask

    task automatic cfg(input int idx, input int x, input int y,
                       input logic [2:0] col, input logic dxn,
                       input logic dyn, input logic en, input logic tick);
        @(negedge vclock);
        wr_en      = 1'b1;
        wr_idx     = 3'(idx);
        wr_x       = 11'(x);
        wr_y       = 10'(y);
        wr_color   = col;
        wr_dx_neg  = dxn;
        wr_dy_neg  = dyn;
        wr_enable  = en;
        frame_tick = tick;
        @(negedge vclock);
        wr_en      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic tick();
        @(negedge vclock);
        frame_tick = 1'b1;
        @(negedge vclock);
        frame_tick = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        hcount     = '0;
        vcount     = '0;
        frame_tick = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_x       = '0;
        wr_y       = '0;
        wr_color   = '0;
        wr_dx_neg  = 1'b0;
        wr_dy_neg  = 1'b0;
        wr_enable  = 1'b0;
        repeat (3) @(negedge vclock);
        check("rst.hit", 32'(hit), 32'd0);
        check("rst.pix", 32'(pixel), 32'd0);
        reset = 1'b0;

        probe("idle0", 0, 0, 0, 0, 0);
        probe("idle1", 100, 50, 0, 0, 0);
        probe("idle2", 1023, 767, 0, 0, 0);

        cfg(0, 100, 50, 3'b101, 0, 0, 1, 0);
        probe("c0.tl", 100, 50, 1, 0, 3'b101);
        probe("c0.l-", 99, 50, 0, 0, 0);
        probe("c0.br", 163, 113, 1, 0, 3'b101);
        probe("c0.r+", 164, 113, 0, 0, 0);
        probe("c0.b+", 163, 114, 0, 0, 0);
        probe("c0.t-", 100, 49, 0, 0, 0);

        // Latency: output reflects the point presented before the last edge
        @(negedge vclock);
        hcount = 11'd120;
        vcount = 10'd60;
        @(negedge vclock);
        hcount = 11'd10;
        vcount = 10'd10;
        #1;
        check("lat.hit", 32'(hit), 32'd1);
        @(negedge vclock);
        check("lat.next", 32'(hit), 32'd0);

        cfg(0, 100, 100, 3'b001, 0, 0, 1, 0);
        cfg(1, 130, 130, 3'b110, 0, 0, 1, 0);
        probe("ovl.a", 140, 140, 1, 0, 3'b001);
        probe("ovl.b", 170, 170, 1, 1, 3'b110);

        cfg(4, 10, 10, 3'b111, 0, 0, 1, 0);
        probe("idx4", 10, 10, 0, 0, 0);

        cfg(1, 0, 0, 3'b000, 0, 0, 0, 0);
        cfg(0, 958, 300, 3'b011, 0, 0, 1, 0);
        tick();
        probe("rb1.in", 960, 302, 1, 0, 3'b011);
        probe("rb1.out", 959, 302, 0, 0, 0);
        tick();
        probe("rb2.in", 960, 304, 1, 0, 3'b011);
        probe("rb2.out", 959, 304, 0, 0, 0);
        tick();
        probe("rb3.in", 958, 306, 1, 0, 3'b011);
        probe("rb3.out", 957, 306, 0, 0, 0);

        cfg(0, 500, 1, 3'b010, 0, 1, 1, 0);
        tick();
        probe("tb1.top", 502, 0, 1, 0, 3'b010);
        probe("tb1.bot", 502, 63, 1, 0, 3'b010);
        probe("tb1.out", 502, 64, 0, 0, 0);
        tick();
        probe("tb2.in", 504, 2, 1, 0, 3'b010);
        probe("tb2.out", 504, 1, 0, 0, 0);

        cfg(0, 200, 200, 3'b001, 0, 0, 1, 0);
        cfg(1, 300, 300, 3'b110, 0, 0, 1, 0);
        cfg(2, 500, 500, 3'b100, 0, 0, 1, 0);
        cfg(2, 400, 500, 3'b100, 0, 0, 1, 1);
        probe("wt.c0", 202, 202, 1, 0, 3'b001);
        probe("wt.c0-", 201, 202, 0, 0, 0);
        probe("wt.c1", 302, 302, 1, 1, 3'b110);
        probe("wt.c2", 400, 500, 1, 2, 3'b100);
        probe("wt.c2-", 399, 500, 0, 0, 0);

        // Reset mid-frame while a rectangle covers the presented point
        @(negedge vclock);
        hcount = 11'd210;
        vcount = 10'd210;
        @(negedge vclock);
        check("pre.hit", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge vclock);
        reset = 1'b0;
        check("mr.hit", 32'(hit), 32'd0);
        check("mr.pix", 32'(pixel), 32'd0);
        tick();
        probe("mr.c0", 210, 210, 0, 0, 0);
        probe("mr.org", 0, 0, 0, 0, 0);
        probe("mr.c2", 402, 502, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rect_sprite_engine.md
# rect_sprite_engine

Parametrised multi-rectangle sprite generator for the XVGA video path: holds position, direction and colour for up to NUM_RECTS rectangles, moves them once per frame with edge bounce, and produces one registered pixel per clock from hcount/vcount. It sits between the XVGA timing generator and the pixel mux. It replaces single static rectangles whose positions are driven from outside.

## Interface
- NUM_RECTS, 4: number of rectangle channels (1-8)
- WIDTH, 64: rectangle width in pixels
- HEIGHT, 64: rectangle height in pixels
- COLOR_W, 3: pixel/colour width (RGB, 1 bit each by default)
- STEP, 2: pixels moved per axis per frame_tick
- H_ACTIVE, 1024: visible columns
- V_ACTIVE, 768: visible rows

- vclock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  11  current column
- vcount  in  10  current row
- frame_tick  in  1  one-cycle pulse, once per frame, issued during vertical blanking
- wr_en  in  1  config write strobe
- wr_idx  in  3  channel index to write (values >= NUM_RECTS ignored)
- wr_x  in  11  new left edge
- wr_y  in  10  new top edge
- wr_color  in  COLOR_W  channel colour
- wr_dx_neg  in  1  1 = moving left
- wr_dy_neg  in  1  1 = moving up
- wr_enable  in  1  channel visible/moving
- pixel  out  COLOR_W  colour for (hcount, vcount) of previous cycle
- hit  out  1  any enabled rectangle covers that point
- hit_idx  out  3  lowest-index covering channel (0 when hit = 0)

## Operation
- Per-channel state: x[10:0], y[9:0], dx_neg, dy_neg, en, color.
- Reset: all channels x = 0, y = 0, dx_neg = 0, dy_neg = 0, en = 0, color = 0; pixel = 0, hit = 0, hit_idx = 0.
- Config write: when wr_en = 1 and wr_idx < NUM_RECTS, all fields of channel wr_idx load on the next edge. Software keeps wr_x <= H_ACTIVE-WIDTH and wr_y <= V_ACTIVE-HEIGHT. Out-of-range values are loaded unchanged and are not clamped.
- Motion: on frame_tick, each enabled channel updates both axes independently. Disabled channels hold their state.
  - x axis, moving right: if x + STEP + WIDTH > H_ACTIVE, then x <= H_ACTIVE-WIDTH and dx_neg <= 1. Otherwise x <= x + STEP.
  - x axis, moving left: if x < STEP, then x <= 0 and dx_neg <= 0. Otherwise x <= x - STEP.
  - y axis: same rules using V_ACTIVE, HEIGHT and dy_neg.
- Arithmetic: edge sums computed 1 bit wider than the operand (12b x, 11b y), so there is no wrap-around.
- Simultaneous wr_en and frame_tick on the same channel: the write wins and the motion update for that channel is dropped. Other channels move normally.
- Hit test for channel i: en & (hcount >= x) & (hcount < x+WIDTH) & (vcount >= y) & (vcount < y+HEIGHT), with widened sums.
- Priority: the lowest index wins. pixel = winner's color, or 0 if there is no hit.

## Timing
- Pixel path latency is exactly 1 cycle: hit, hit_idx and pixel register the result for the hcount/vcount presented on the previous edge. The upstream blank/sync are delayed 1 cycle to match.
- The hit test uses current register values. A write or motion update takes effect for hcount/vcount sampled on the cycle after the update edge.
- frame_tick is level-insensitive beyond its one cycle. Back-to-back ticks produce two moves.
- Reset asserted mid-frame clears all state on that edge. Outputs are 0 on the following cycle.

## Structure
- Shared package video_pkg: H_ACTIVE/V_ACTIVE defaults, HCOUNT_W = 11, VCOUNT_W = 10, and the channel-state record typedef (x, y, dx_neg, dy_neg, en, color).
- Sub-module rect_hit: combinational per-channel containment test (inputs: x, y, en, hcount, vcount; parameters WIDTH, HEIGHT). It is instantiated NUM_RECTS times via generate.
- The top level holds the channel register array, motion/bounce logic, priority encoder and output registers.

## Test plan
- Reset, then sweep hcount/vcount → pixel = 0 and hit = 0 everywhere. Write ch0 (x = 100, y = 50, color = 3'b101, en = 1) → pixel = 3'b101 exactly for 100 <= h < 164 and 50 <= v < 114, one cycle late.
- Overlap ch0 (100, 100, 3'b001) with ch1 (130, 130, 3'b110) → at (140, 140), hit_idx = 0 and pixel = 3'b001. At (170, 170), hit_idx = 1 and pixel = 3'b110.
- Right-edge bounce: ch0 x = 958, moving right, WIDTH 64, STEP 2 → after tick, x = 960 and dx_neg = 0. After the next tick, x = 960 and dx_neg = 1. After the following tick, x = 958.
- Top-edge bounce: y = 1, moving up → after tick, y = 0 and dy_neg = 0. After the next tick, y = 2.
- wr_en to ch2 (x = 400) in the same cycle as frame_tick → ch2 x = 400 with no step applied. The other enabled channels advance by STEP.
- Assert reset mid-frame with all channels enabled → the next cycle has pixel = 0 and hit = 0, and the following frame_tick moves nothing.
